// File: rtl/uart_time_cmd_decoder.sv
// Decodes "THH:MM:SS<CR>" frames arriving one byte per rx_done into a range-checked BCD time.
// Define CMD_ACK_EN to add a 'K'/'E' acknowledge byte channel with a valid/ready handshake.
module uart_time_cmd_decoder #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [23:0] time_bcd,
  output logic        load,
  output logic        err,
  output logic        busy,
  output logic [7:0]  err_cnt
`ifdef CMD_ACK_EN
  ,
  output logic [7:0]  ack_data,
  output logic        ack_valid,
  input  logic        ack_ready
`endif
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] CH_T   = 8'h54;
  localparam logic [7:0] CH_COL = 8'h3A;
  localparam logic [7:0] CH_CR  = 8'h0D;

  // States are declared in frame order so an accepted byte simply steps to the next one.
  typedef enum logic [3:0] {
    S_IDLE, S_H1, S_H0, S_C1, S_M1, S_M0, S_C2, S_S1, S_S0, S_END
  } state_t;

  state_t        r_state;
  logic [3:0]    r_h1, r_h0, r_m1, r_m0, r_s1, r_s0;
  logic [TW-1:0] r_tmo;
  logic [23:0]   r_time;
  logic          r_load;
  logic          r_err;
  logic          r_busy;
  logic [7:0]    r_err_cnt;

  logic       w_is_digit;
  logic [3:0] w_digit;
  logic       w_range_ok;
  logic       w_accept;
  logic       w_timeout;
  logic       w_take_load;
  logic       w_take_err;
  logic       w_resync;

  assign w_is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign w_digit    = 4'(rx_data - 8'h30);
  assign w_resync   = (rx_data == CH_T);
  assign w_range_ok = ((r_h1 < 4'd2) || ((r_h1 == 4'd2) && (r_h0 <= 4'd3))) &&
                      (r_m1 <= 4'd5) && (r_s1 <= 4'd5);

  always_comb begin
    w_accept = 1'b0;
    case (r_state)
      S_H1, S_H0, S_M1, S_M0, S_S1, S_S0: w_accept = w_is_digit;
      S_C1, S_C2:                         w_accept = (rx_data == CH_COL);
      S_END:                              w_accept = (rx_data == CH_CR) && w_range_ok;
      default:                            w_accept = 1'b0;
    endcase
  end

  // A byte arriving on the terminal idle cycle wins over the timeout.
  assign w_timeout   = (r_state != S_IDLE) && !rx_done && (r_tmo == TMO_LAST);
  assign w_take_load = rx_done && (r_state == S_END) && w_accept;
  assign w_take_err  = (rx_done && (r_state != S_IDLE) && !w_accept) || w_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_time    <= 24'h000000;
      r_load    <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_err_cnt <= 8'd0;
      r_tmo     <= '0;
    end else begin
      r_load <= w_take_load;
      r_err  <= w_take_err;
      if (w_take_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      if ((r_state == S_IDLE) || rx_done || w_timeout) r_tmo <= '0;
      else                                             r_tmo <= r_tmo + 1'b1;
      if (w_take_load) r_time <= {r_h1, r_h0, r_m1, r_m0, r_s1, r_s0};

      if (w_timeout) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else if (rx_done) begin
        if (r_state == S_IDLE) begin
          if (w_resync) begin
            r_state <= S_H1;
            r_busy  <= 1'b1;
          end
        end else if (!w_accept) begin
          r_state <= w_resync ? S_H1 : S_IDLE;
          r_busy  <= w_resync;
        end else if (r_state == S_END) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end else begin
          r_state <= state_t'(r_state + 4'd1);
        end
      end
    end
  end

  // Digit holding registers need no reset: every digit is rewritten before END can accept CR.
  always_ff @(posedge clk) begin
    if (rx_done && w_accept) begin
      case (r_state)
        S_H1:    r_h1 <= w_digit;
        S_H0:    r_h0 <= w_digit;
        S_M1:    r_m1 <= w_digit;
        S_M0:    r_m0 <= w_digit;
        S_S1:    r_s1 <= w_digit;
        S_S0:    r_s0 <= w_digit;
        default: ;
      endcase
    end
  end

  assign time_bcd = r_time;
  assign load     = r_load;
  assign err      = r_err;
  assign busy     = r_busy;
  assign err_cnt  = r_err_cnt;

`ifdef CMD_ACK_EN
  logic [7:0] r_ack_data;
  logic       r_ack_valid;

  // A new event overwrites a pending acknowledge rather than queueing behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack_valid <= 1'b0;
      r_ack_data  <= 8'h00;
    end else if (w_take_load) begin
      r_ack_valid <= 1'b1;
      r_ack_data  <= 8'h4B;
    end else if (w_take_err) begin
      r_ack_valid <= 1'b1;
      r_ack_data  <= 8'h45;
    end else if (r_ack_valid && ack_ready) begin
      r_ack_valid <= 1'b0;
    end
  end

  assign ack_data  = r_ack_data;
  assign ack_valid = r_ack_valid;
`endif

endmodule

// File: tb/tb_uart_time_cmd_decoder.sv
// Bench for uart_time_cmd_decoder: frame table, hand-built timing corners and a randomized byte stream
// compared every cycle against a positional frame model.
module tb_uart_time_cmd_decoder;

  localparam int TMO = 16;
  localparam logic [7:0] CR = 8'h0D;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [23:0] time_bcd;
  logic        load;
  logic        err;
  logic        busy;
  logic [7:0]  err_cnt;
`ifdef CMD_ACK_EN
  logic [7:0]  ack_data;
  logic        ack_valid;
  logic        ack_ready;
  logic        m_ackv;
  logic [7:0]  m_ackd;
  bit          rand_rdy = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_time_cmd_decoder #(.TIMEOUT_CYC(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .time_bcd (time_bcd),
    .load     (load),
    .err      (err),
    .busy     (busy),
    .err_cnt  (err_cnt)
`ifdef CMD_ACK_EN
    ,
    .ack_data (ack_data),
    .ack_valid(ack_valid),
    .ack_ready(ack_ready)
`endif
  );

  int checks = 0;
  int failures = 0;
  int n_load = 0;
  int n_err = 0;

  // Reference model: m_pos = number of frame bytes received so far (0 = waiting for 'T').
  int          m_pos, m_idle, m_cnt;
  logic [7:0]  m_buf [10];
  logic [23:0] m_time;
  logic        m_load, m_err, m_busy;

  typedef struct {
    string       txt;
    bit          cr;
    int          exp_load;
    int          exp_err;
    logic [23:0] exp_time;
    int          exp_cnt;
    bit          exp_busy;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int dig(input logic [7:0] b);
    return int'(b) - 48;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic bit byte_ok(input int pos, input logic [7:0] b);
    case (pos)
      1, 2, 4, 5, 7, 8: return (b >= 8'h30) && (b <= 8'h39);
      3, 6:             return b == 8'h3A;
      9:                return (b == CR) && ((dig(m_buf[1]) * 10 + dig(m_buf[2])) <= 23) &&
                               (dig(m_buf[4]) <= 5) && (dig(m_buf[7]) <= 5);
      default:          return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_pos = 0; m_idle = 0; m_cnt = 0; m_time = 24'h0;
    m_load = 1'b0; m_err = 1'b0; m_busy = 1'b0;
`ifdef CMD_ACK_EN
    m_ackv = 1'b0; m_ackd = 8'h00;
`endif
  endtask

  task automatic model_step(input logic d, input logic [7:0] b);
    m_load = 1'b0;
    m_err  = 1'b0;
    if (d) begin
      if (m_pos == 0) begin
        if (b == 8'h54) begin m_pos = 1; m_buf[0] = b; end
      end else if (byte_ok(m_pos, b)) begin
        m_buf[m_pos] = b;
        if (m_pos == 9) begin
          m_time = {to_bcd(dig(m_buf[1]) * 10 + dig(m_buf[2])),
                    to_bcd(dig(m_buf[4]) * 10 + dig(m_buf[5])),
                    to_bcd(dig(m_buf[7]) * 10 + dig(m_buf[8]))};
          m_load = 1'b1;
          m_pos  = 0;
        end else begin
          m_pos++;
        end
      end else begin
        m_err = 1'b1;
        m_pos = (b == 8'h54) ? 1 : 0;
      end
      m_idle = 0;
    end else if (m_pos != 0) begin
      m_idle++;
      if (m_idle == TMO) begin m_err = 1'b1; m_pos = 0; m_idle = 0; end
    end
    if (m_err && (m_cnt < 255)) m_cnt++;
    m_busy = (m_pos != 0);
`ifdef CMD_ACK_EN
    if (m_ackv && ack_ready) m_ackv = 1'b0;
    if (m_load)     begin m_ackv = 1'b1; m_ackd = 8'h4B; end
    else if (m_err) begin m_ackv = 1'b1; m_ackd = 8'h45; end
`endif
  endtask

  task automatic compare_all();
    chk("load", 32'(load), 32'(m_load));
    chk("err", 32'(err), 32'(m_err));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("time_bcd", 32'(time_bcd), 32'(m_time));
    chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
    chk("load_and_err", 32'(load & err), 32'd0);
`ifdef CMD_ACK_EN
    chk("ack_valid", 32'(ack_valid), 32'(m_ackv));
    if (m_ackv) chk("ack_data", 32'(ack_data), 32'(m_ackd));
`endif
    n_load += int'(load);
    n_err  += int'(err);
  endtask

  task automatic cycle(input logic d, input logic [7:0] b);
    rx_done = d;
    rx_data = d ? b : 8'($urandom);
`ifdef CMD_ACK_EN
    if (rand_rdy) ack_ready = 1'($urandom);
`endif
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(d, rx_data);
    @(negedge clk);
    compare_all();
    rx_done = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) cycle(1'b0, 8'h00);
    cycle(1'b1, b);
  endtask

  task automatic send_str(input string s, input int maxgap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], $urandom_range(0, maxgap));
  endtask

  task automatic add_vec(input string t, input bit c, input int l, input int e,
                         input logic [23:0] tm, input int cnt, input bit bz);
    vec_t v;
    v.txt = t; v.cr = c; v.exp_load = l; v.exp_err = e;
    v.exp_time = tm; v.exp_cnt = cnt; v.exp_busy = bz;
    vq.push_back(v);
  endtask

  initial begin
    int l0, e0;
    logic [7:0] fb [$];

    rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00;
`ifdef CMD_ACK_EN
    ack_ready = 1'b1;
`endif
    model_reset();
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    chk("reset_time", 32'(time_bcd), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_err_cnt", 32'(err_cnt), 32'h0);
    rst = 1'b0;
    cycle(1'b0, 8'h00);

    add_vec("T12:34:56",          1, 1, 0, 24'h123456, 0, 0);
    add_vec("T24:00:00",          1, 0, 1, 24'h123456, 1, 0);
    add_vec("T1T08:15:30",        1, 1, 1, 24'h081530, 2, 0);
    add_vec("xyT23:59:59",        1, 1, 0, 24'h235959, 2, 0);
    add_vec("T12:60:00",          1, 0, 1, 24'h235959, 3, 0);
    add_vec("T00:00:00X",         0, 0, 1, 24'h235959, 4, 0);
    add_vec("T19:07:08",          1, 1, 0, 24'h190708, 4, 0);
    add_vec("T35:00:00",          1, 0, 1, 24'h190708, 5, 0);
    add_vec("T12:34:5T00:00:01",  1, 1, 1, 24'h000001, 6, 0);
    add_vec("T12A",               0, 0, 1, 24'h000001, 7, 0);
    add_vec("T20:00:0",           1, 0, 1, 24'h000001, 8, 0);

    foreach (vq[i]) begin
      l0 = n_load; e0 = n_err;
      send_str(vq[i].txt, 2);
      if (vq[i].cr) send_byte(CR, $urandom_range(0, 2));
      repeat (3) cycle(1'b0, 8'h00);
      chk($sformatf("vec%0d_loads", i), 32'(n_load - l0), 32'(vq[i].exp_load));
      chk($sformatf("vec%0d_errs", i), 32'(n_err - e0), 32'(vq[i].exp_err));
      chk($sformatf("vec%0d_time", i), 32'(time_bcd), 32'(vq[i].exp_time));
      chk($sformatf("vec%0d_err_cnt", i), 32'(err_cnt), 32'(vq[i].exp_cnt));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vq[i].exp_busy));
    end

    // Timeout: TMO idle cycles after "T09:" abort the frame.
    e0 = n_err;
    send_str("T09:", 0);
    repeat (TMO - 1) cycle(1'b0, 8'h00);
    chk("tmo_no_early_err", 32'(n_err - e0), 32'd0);
    chk("tmo_busy_before", 32'(busy), 32'd1);
    cycle(1'b0, 8'h00);
    chk("tmo_err_pulse", 32'(err), 32'd1);
    chk("tmo_busy_after", 32'(busy), 32'd0);
    cycle(1'b0, 8'h00);
    chk("tmo_err_one_cycle", 32'(err), 32'd0);
    chk("tmo_err_cnt", 32'(err_cnt), 32'd9);

    // A byte on the terminal cycle is processed instead of timing out.
    e0 = n_err; l0 = n_load;
    send_str("T09:", 0);
    repeat (TMO - 1) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h33);
    cycle(1'b0, 8'h00);
    chk("term_no_err", 32'(n_err - e0), 32'd0);
    chk("term_busy", 32'(busy), 32'd1);
    send_str("0:00", 0);
    send_byte(CR, 0);
    chk("term_load", 32'(load), 32'd1);
    chk("term_time", 32'(time_bcd), 32'h093000);
    chk("term_loads", 32'(n_load - l0), 32'd1);

    // Reset in mid-frame discards it silently.
    send_str("T2", 0);
    chk("rst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_time", 32'(time_bcd), 32'h0);
    chk("rst_async_err_cnt", 32'(err_cnt), 32'd0);
    model_reset();
    e0 = n_err; l0 = n_load;
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    rst = 1'b0;
    send_str("T23:59:59", 1);
    send_byte(CR, 1);
    cycle(1'b0, 8'h00);
    chk("rst_no_err", 32'(n_err - e0), 32'd0);
    chk("rst_then_load", 32'(n_load - l0), 32'd1);
    chk("rst_then_time", 32'(time_bcd), 32'h235959);

`ifdef CMD_ACK_EN
    ack_ready = 1'b0;
    send_str("T01:02:03", 1);
    send_byte(CR, 1);
    repeat (3) cycle(1'b0, 8'h00);
    chk("ack_valid_held", 32'(ack_valid), 32'd1);
    chk("ack_data_k", 32'(ack_data), 32'h4B);
    ack_ready = 1'b1;
    cycle(1'b0, 8'h00);
    ack_ready = 1'b0;
    chk("ack_valid_cleared", 32'(ack_valid), 32'd0);
    send_str("T01:02:03", 0);
    send_byte(CR, 0);
    send_str("TX", 0);
    cycle(1'b0, 8'h00);
    chk("ack_overwrite_valid", 32'(ack_valid), 32'd1);
    chk("ack_overwrite_e", 32'(ack_data), 32'h45);
    ack_ready = 1'b1;
    cycle(1'b0, 8'h00);
    rand_rdy = 1'b1;
`endif

    // Randomized frames: out-of-range fields, corrupted bytes, idle noise and gaps around the timeout.
    for (int f = 0; f < 200; f++) begin
      int h, mi, s, gsel;
      h  = $urandom_range(0, 29);
      mi = $urandom_range(0, 69);
      s  = $urandom_range(0, 69);
      fb.delete();
      if ($urandom_range(0, 4) == 0) fb.push_back(8'($urandom));
      fb.push_back(8'h54);
      fb.push_back(8'(48 + h / 10));  fb.push_back(8'(48 + h % 10));  fb.push_back(8'h3A);
      fb.push_back(8'(48 + mi / 10)); fb.push_back(8'(48 + mi % 10)); fb.push_back(8'h3A);
      fb.push_back(8'(48 + s / 10));  fb.push_back(8'(48 + s % 10));  fb.push_back(CR);
      if ($urandom_range(0, 7) == 0) fb[$urandom_range(0, fb.size() - 1)] = 8'($urandom);
      foreach (fb[k]) begin
        gsel = $urandom_range(0, 40);
        if (gsel == 0)      send_byte(fb[k], TMO - 1);
        else if (gsel == 1) send_byte(fb[k], TMO);
        else if (gsel == 2) send_byte(fb[k], TMO + 1);
        else                send_byte(fb[k], $urandom_range(0, 3));
      end
    end
`ifdef CMD_ACK_EN
    rand_rdy = 1'b0;
    ack_ready = 1'b1;
`endif
    repeat (TMO + 2) cycle(1'b0, 8'h00);

    // Saturation of the error counter.
    for (int n = 0; n < 260; n++) send_str("TX", 0);
    cycle(1'b0, 8'h00);
    chk("err_cnt_saturated", 32'(err_cnt), 32'd255);
    chk("sat_busy_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_time_cmd_decoder.md
UART_TIME_CMD_DECODER -- requirements
Module: uart_time_cmd_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1000000; the number of idle clk cycles allowed between bytes inside a frame.
REQ-002 SHALL have port clk, input, 1, the single system clock.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-004 SHALL have port rx_data, input, 8, the received byte; valid only while rx_done=1.
REQ-005 SHALL have port rx_done, input, 1, one-cycle strobe marking a new byte.
REQ-006 SHALL have port time_bcd, output, 24, the {hour,min,sec} as BCD digit pairs.
REQ-007 SHALL have port load, output, 1, one-cycle pulse meaning time_bcd holds a validated time.
REQ-008 SHALL have port err, output, 1, one-cycle pulse meaning a frame was aborted.
REQ-009 SHALL have port busy, output, 1, high while a frame is partially received.
REQ-010 SHALL have port err_cnt, output, 8, a saturating count of aborted frames.
REQ-011 SHALL have ports ack_data (output, 8), ack_valid (output, 1) and ack_ready (input, 1), present only with CMD_ACK_EN.

Function
REQ-012 SHALL decode the frame 'T'(0x54), H1, H0, ':'(0x3A), M1, M0, ':', S1, S0, CR(0x0D), one byte per rx_done.
REQ-013 SHALL implement the states IDLE, H1, H0, C1, M1, M0, C2, S1, S0, END.
- Each accepted byte advances exactly one state.
- Cycles without rx_done hold the state.
REQ-014 SHALL, in IDLE, ignore every byte other than 'T'; on 'T' it moves to H1.
REQ-015 SHALL, in a digit state, accept only 0x30-0x39 and store (byte - 0x30) into the matching 4-bit nibble.
REQ-016 SHALL, in C1 and C2, accept only ':'.
REQ-017 SHALL, on any unexpected byte outside IDLE, pulse err, increment err_cnt, and go to IDLE.
- Exception: if that byte is 'T', go to H1 instead (resync).
REQ-018 SHALL check ranges at CR in END:
- H1 is 0-2.
- Hour is 00-23.
- M1 and S1 are 0-5.
REQ-019 SHALL, on a CR with valid ranges, update time_bcd and pulse load in the cycle after the rx_done edge that carried CR, then return to IDLE.
REQ-020 SHALL, on a CR with a range violation or on a non-CR byte in END, take the REQ-017 path and leave time_bcd unchanged.
REQ-021 SHALL keep time_bcd unchanged except on a load.
REQ-022 SHALL drive busy=1 in every state except IDLE.
REQ-023 SHALL use a timeout counter:
- Cleared on every rx_done and while in IDLE.
- When it reaches TIMEOUT_CYC outside IDLE: pulse err, increment err_cnt, go to IDLE.
REQ-024 SHALL give rx_done priority when rx_done coincides with the timeout terminal count (the byte is processed, no timeout).
REQ-025 SHALL saturate err_cnt at 255.
REQ-026 SHALL never assert load and err in the same cycle.

Reset
REQ-027 SHALL, while rst=1, asynchronously force:
- state to IDLE;
- time_bcd to 0x000000;
- load, err, busy and ack_valid to 0;
- err_cnt, the timeout counter and ack_data to 0.
REQ-028 SHALL, on reset in mid-frame, discard the partial frame without pulsing err.

Configuration
REQ-029 SHALL use the macro CMD_ACK_EN for the acknowledge feature.
REQ-030 SHALL, when CMD_ACK_EN is defined, handle acknowledges as follows:
- Each load or err cycle sets ack_valid=1, with ack_data='K'(0x4B) for a load or 'E'(0x45) for an err.
- ack_valid and ack_data hold until a cycle with ack_valid=1 and ack_ready=1, then ack_valid clears.
- A new event while ack_valid=1 overwrites ack_data and keeps ack_valid high.
REQ-031 SHALL, when CMD_ACK_EN is undefined, omit the ack ports and logic, with all other behaviour identical.

Verification
REQ-032 SHALL cover: send "T12:34:56\r" -> one load pulse with time_bcd=0x123456, err=0, busy low after the pulse.
REQ-033 SHALL cover: send "T24:00:00\r" -> err pulse, err_cnt=1, time_bcd unchanged, no load.
REQ-034 SHALL cover: send "T1T08:15:30\r" -> one err at the second 'T', then load with 0x081530.
REQ-035 SHALL cover: send "T09:" then no rx_done for TIMEOUT_CYC cycles -> err pulse and busy=0; also a rx_done landing on the terminal cycle -> no err.
REQ-036 SHALL cover: assert rst after "T2" -> busy=0 and no err; then "T23:59:59\r" -> load with 0x235959.
REQ-037 SHALL cover, with CMD_ACK_EN: hold ack_ready=0 through a valid frame -> ack_valid=1, ack_data=0x4B held; then ack_ready=1 for one cycle -> ack_valid=0.
